// File: rtl/jb_dl_dfe_stream_en_ctrl.sv
// Frame-aligned commit of per-carrier DL DFE stream enables; latency: commit 1 cycle after marker edge (+cfg_apply_dly x1en ticks).
// Backpressure: none; a request while busy is dropped and flagged. Optional marker watchdog: JB_DL_DFE_STREAM_CTRL_WDOG_EN.
// All outputs registered; cfg_abort overrides every transition in its cycle.
module jb_dl_dfe_stream_en_ctrl #(
    parameter int N_CARRIERS = 2,
    parameter int N_ANTENNAS = 4,
    parameter int DLY_W      = 16
) (
    input  logic                             clk_1x,
    input  logic                             reset,
    input  logic [N_CARRIERS-1:0]            clk_x1en,
    input  logic [N_CARRIERS-1:0]            dl_dfe_frm_mrkr,
    input  logic [N_CARRIERS*N_ANTENNAS-1:0] cfg_stream_en_req,
    input  logic                             cfg_update_req,
    input  logic                             cfg_abort,
    input  logic [DLY_W-1:0]                 cfg_apply_dly,
    input  logic [DLY_W-1:0]                 cfg_mrkr_timeout,
    output logic [N_CARRIERS*N_ANTENNAS-1:0] dl_stream_en,
    output logic                             update_busy,
    output logic                             update_done,
    output logic [15:0]                      update_cnt,
    output logic                             req_drop,
    output logic [N_CARRIERS-1:0]            mrkr_timeout
);

    localparam int MAP_W = N_CARRIERS * N_ANTENNAS;
    localparam logic [DLY_W-1:0] DLY_ONE = 1;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ARMED = 2'd1,
        ST_DELAY = 2'd2
    } state_t;

    state_t                  r_state     [N_CARRIERS];
    state_t                  w_state_nxt [N_CARRIERS];
    logic [DLY_W-1:0]        r_dly_cnt   [N_CARRIERS];
    logic [N_CARRIERS-1:0]   r_mrkr_prev;
    logic [MAP_W-1:0]        r_shadow;
    logic [MAP_W-1:0]        r_stream_en;
    logic                    r_busy;
    logic                    r_done;
    logic [15:0]             r_cnt;
    logic                    r_req_drop;
    logic                    r_any_commit;

    logic                    w_arm;
    logic                    w_drop;
    logic [N_CARRIERS-1:0]   w_edge;
    logic [N_CARRIERS-1:0]   w_commit;
    logic [N_CARRIERS-1:0]   w_tmo;
    logic                    w_busy_nxt;
    logic                    w_done;

`ifdef JB_DL_DFE_STREAM_CTRL_WDOG_EN
    logic [DLY_W-1:0]        r_tmo_cnt   [N_CARRIERS];
    logic [N_CARRIERS-1:0]   r_mrkr_tmo;
`else
    logic                    w_unused_tmo;
    assign w_unused_tmo = ^{cfg_mrkr_timeout, w_tmo};
`endif

    // State register
    always_ff @(posedge clk_1x) begin
        for (int c = 0; c < N_CARRIERS; c++) begin
            if (reset) begin
                r_state[c] <= ST_IDLE;
            end else begin
                r_state[c] <= w_state_nxt[c];
            end
        end
    end

    // Next-state logic; abort is applied last so it overrides everything
    always_comb begin
        w_arm    = cfg_update_req && !cfg_abort && !r_busy;
        w_drop   = cfg_update_req && !cfg_abort && r_busy;
        w_edge   = '0;
        w_commit = '0;
        w_tmo    = '0;
        for (int c = 0; c < N_CARRIERS; c++) begin
            w_state_nxt[c] = r_state[c];
            w_edge[c]      = clk_x1en[c] & dl_dfe_frm_mrkr[c] & ~r_mrkr_prev[c];
            case (r_state[c])
                ST_IDLE: begin
                    if (w_arm) begin
                        w_state_nxt[c] = ST_ARMED;
                    end
                end
                ST_ARMED: begin
                    if (w_edge[c]) begin
                        if (cfg_apply_dly == '0) begin
                            w_commit[c]    = 1'b1;
                            w_state_nxt[c] = ST_IDLE;
                        end else begin
                            w_state_nxt[c] = ST_DELAY;
                        end
                    end
`ifdef JB_DL_DFE_STREAM_CTRL_WDOG_EN
                    else if (clk_x1en[c] && (r_tmo_cnt[c] + DLY_ONE == cfg_mrkr_timeout)) begin
                        w_tmo[c]       = 1'b1;
                        w_state_nxt[c] = ST_IDLE;
                    end
`endif
                end
                ST_DELAY: begin
                    if (clk_x1en[c] && (r_dly_cnt[c] == cfg_apply_dly)) begin
                        w_commit[c]    = 1'b1;
                        w_state_nxt[c] = ST_IDLE;
                    end
                end
                default: w_state_nxt[c] = ST_IDLE;
            endcase
            if (cfg_abort) begin
                w_state_nxt[c] = ST_IDLE;
                w_commit[c]    = 1'b0;
                w_tmo[c]       = 1'b0;
            end
        end
    end

    // Output decode: done only when the update ends with at least one commit
    always_comb begin
        w_busy_nxt = 1'b0;
        for (int c = 0; c < N_CARRIERS; c++) begin
            if (w_state_nxt[c] != ST_IDLE) begin
                w_busy_nxt = 1'b1;
            end
        end
        w_done = r_busy && !cfg_abort && !w_busy_nxt && (r_any_commit || (|w_commit));
    end

    always_ff @(posedge clk_1x) begin
        if (reset) begin
            r_mrkr_prev  <= '0;
            r_shadow     <= '0;
            r_stream_en  <= '0;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
            r_cnt        <= '0;
            r_req_drop   <= 1'b0;
            r_any_commit <= 1'b0;
            for (int c = 0; c < N_CARRIERS; c++) begin
                r_dly_cnt[c] <= '0;
            end
        end else begin
            for (int c = 0; c < N_CARRIERS; c++) begin
                if (clk_x1en[c]) begin
                    r_mrkr_prev[c] <= dl_dfe_frm_mrkr[c];
                end
                if (r_state[c] == ST_ARMED && w_edge[c]) begin
                    r_dly_cnt[c] <= DLY_ONE;
                end else if (r_state[c] == ST_DELAY && clk_x1en[c]) begin
                    r_dly_cnt[c] <= r_dly_cnt[c] + DLY_ONE;
                end
                if (w_commit[c]) begin
                    r_stream_en[c*N_ANTENNAS +: N_ANTENNAS] <= r_shadow[c*N_ANTENNAS +: N_ANTENNAS];
                end
            end
            if (w_arm) begin
                r_shadow <= cfg_stream_en_req;
            end
            if (w_drop) begin
                r_req_drop <= 1'b1;
            end
            r_busy <= w_busy_nxt;
            r_done <= w_done;
            if (w_done) begin
                r_cnt <= r_cnt + 16'd1;
            end
            if (!w_busy_nxt) begin
                r_any_commit <= 1'b0;
            end else if (|w_commit) begin
                r_any_commit <= 1'b1;
            end
        end
    end

`ifdef JB_DL_DFE_STREAM_CTRL_WDOG_EN
    always_ff @(posedge clk_1x) begin
        if (reset) begin
            r_mrkr_tmo <= '0;
            for (int c = 0; c < N_CARRIERS; c++) begin
                r_tmo_cnt[c] <= '0;
            end
        end else begin
            for (int c = 0; c < N_CARRIERS; c++) begin
                if (w_arm) begin
                    r_tmo_cnt[c] <= '0;
                end else if (r_state[c] == ST_ARMED && clk_x1en[c] && !w_edge[c]) begin
                    r_tmo_cnt[c] <= r_tmo_cnt[c] + DLY_ONE;
                end
                if (w_tmo[c]) begin
                    r_mrkr_tmo[c] <= 1'b1;
                end
            end
        end
    end
    assign mrkr_timeout = r_mrkr_tmo;
`else
    assign mrkr_timeout = '0;
`endif

    assign dl_stream_en = r_stream_en;
    assign update_busy  = r_busy;
    assign update_done  = r_done;
    assign update_cnt   = r_cnt;
    assign req_drop     = r_req_drop;

endmodule

// File: tb/tb_jb_dl_dfe_stream_en_ctrl.sv
// Directed self-checking bench for jb_dl_dfe_stream_en_ctrl; expected values hand-computed per scenario.
module tb_jb_dl_dfe_stream_en_ctrl;

    logic        clk_1x = 1'b0;
    logic        reset;
    logic [1:0]  clk_x1en;
    logic [1:0]  dl_dfe_frm_mrkr;
    logic [7:0]  cfg_stream_en_req;
    logic        cfg_update_req;
    logic        cfg_abort;
    logic [15:0] cfg_apply_dly;
    logic [15:0] cfg_mrkr_timeout;
    logic [7:0]  dl_stream_en;
    logic        update_busy;
    logic        update_done;
    logic [15:0] update_cnt;
    logic        req_drop;
    logic [1:0]  mrkr_timeout;

    int n_tests = 0;
    int n_fail  = 0;

    jb_dl_dfe_stream_en_ctrl dut (
        .clk_1x            (clk_1x),
        .reset             (reset),
        .clk_x1en          (clk_x1en),
        .dl_dfe_frm_mrkr   (dl_dfe_frm_mrkr),
        .cfg_stream_en_req (cfg_stream_en_req),
        .cfg_update_req    (cfg_update_req),
        .cfg_abort         (cfg_abort),
        .cfg_apply_dly     (cfg_apply_dly),
        .cfg_mrkr_timeout  (cfg_mrkr_timeout),
        .dl_stream_en      (dl_stream_en),
        .update_busy       (update_busy),
        .update_done       (update_done),
        .update_cnt        (update_cnt),
        .req_drop          (req_drop),
        .mrkr_timeout      (mrkr_timeout)
    );

    always #5 clk_1x = ~clk_1x;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    // Inputs set before the call are captured by the next edge; outputs read 1ns after it
    task automatic cyc(input int n = 1);
        for (int k = 0; k < n; k++) begin
            @(posedge clk_1x);
            #1;
        end
    endtask

    task automatic arm(input logic [7:0] map);
        cfg_stream_en_req = map;
        cfg_update_req    = 1'b1;
        cyc();
        cfg_update_req    = 1'b0;
    endtask

    initial begin
        reset             = 1'b1;
        clk_x1en          = 2'b11;
        dl_dfe_frm_mrkr   = 2'b00;
        cfg_stream_en_req = 8'h00;
        cfg_update_req    = 1'b0;
        cfg_abort         = 1'b0;
        cfg_apply_dly     = 16'd3;
        cfg_mrkr_timeout  = 16'd50;
        cyc(3);
        reset = 1'b0;
        cyc();
        check("rst_stream", dl_stream_en, 0);
        check("rst_busy",   update_busy, 0);
        check("rst_done",   update_done, 0);
        check("rst_cnt",    update_cnt, 0);
        check("rst_drop",   req_drop, 0);
        check("rst_tmo",    mrkr_timeout, 0);

        // Commit with delay 3: slice appears 4 edges after the edge that sees the marker
        arm(8'hA5);
        check("dly_busy_arm", update_busy, 1);
        cyc(3);
        dl_dfe_frm_mrkr = 2'b01;
        cyc(3);
        check("dly_c0_early", dl_stream_en, 8'h00);
        cyc();
        check("dly_c0_commit", dl_stream_en, 8'h05);
        check("dly_c0_nodone", update_done, 0);
        cyc(2);
        dl_dfe_frm_mrkr = 2'b11;
        cyc(3);
        check("dly_c1_early", dl_stream_en, 8'h05);
        check("dly_busy_mid", update_busy, 1);
        cyc();
        check("dly_c1_commit", dl_stream_en, 8'hA5);
        check("dly_done",      update_done, 1);
        check("dly_busy_fall", update_busy, 0);
        check("dly_cnt",       update_cnt, 1);
        cyc();
        check("dly_done_pulse", update_done, 0);
        dl_dfe_frm_mrkr = 2'b00;
        cyc(2);

        // Marker already high at arm must not commit; the later rise does
        cfg_apply_dly   = 16'd0;
        dl_dfe_frm_mrkr = 2'b11;
        cyc(2);
        arm(8'h3C);
        cyc(3);
        check("pre_no_commit", dl_stream_en, 8'hA5);
        check("pre_busy", update_busy, 1);
        dl_dfe_frm_mrkr = 2'b00;
        cyc(8);
        check("pre_still_old", dl_stream_en, 8'hA5);
        dl_dfe_frm_mrkr = 2'b11;
        cyc();
        check("pre_commit", dl_stream_en, 8'h3C);
        check("pre_done",   update_done, 1);
        check("pre_cnt",    update_cnt, 2);
        dl_dfe_frm_mrkr = 2'b00;
        cyc(2);

        // Second request while busy is dropped; first map commits
        arm(8'h0F);
        arm(8'hFF);
        check("drop_flag", req_drop, 1);
        dl_dfe_frm_mrkr = 2'b11;
        cyc();
        check("drop_commit", dl_stream_en, 8'h0F);
        check("drop_cnt",    update_cnt, 3);
        dl_dfe_frm_mrkr = 2'b00;
        cyc(2);

        // Abort while carrier0 is in DELAY
        cfg_apply_dly = 16'd5;
        arm(8'hF0);
        dl_dfe_frm_mrkr = 2'b01;
        cyc(3);
        cfg_abort = 1'b1;
        cyc();
        cfg_abort = 1'b0;
        check("abort_busy",   update_busy, 0);
        check("abort_done",   update_done, 0);
        check("abort_stream", dl_stream_en, 8'h0F);
        dl_dfe_frm_mrkr = 2'b00;
        cyc(8);
        check("abort_stream_late", dl_stream_en, 8'h0F);
        check("abort_cnt", update_cnt, 3);

        // Watchdog: carrier1 never sees a marker
        cfg_apply_dly    = 16'd0;
        cfg_mrkr_timeout = 16'd50;
        arm(8'h5A);
        dl_dfe_frm_mrkr = 2'b01;
        cyc();
        check("wd_c0_commit", dl_stream_en, 8'h0A);
`ifdef JB_DL_DFE_STREAM_CTRL_WDOG_EN
        cyc(48);
        check("wd_tmo_early",  mrkr_timeout, 2'b00);
        check("wd_busy_early", update_busy, 1);
        cyc();
        check("wd_tmo",  mrkr_timeout, 2'b10);
        check("wd_done", update_done, 1);
        check("wd_busy", update_busy, 0);
        check("wd_cnt",  update_cnt, 4);
        cyc();
        check("wd_done_once", update_done, 0);
`else
        cyc(60);
        check("nowd_busy", update_busy, 1);
        check("nowd_tmo",  mrkr_timeout, 2'b00);
        check("nowd_done", update_done, 0);
        cfg_abort = 1'b1;
        cyc();
        cfg_abort = 1'b0;
        check("nowd_abort_busy", update_busy, 0);
        check("nowd_cnt", update_cnt, 3);
`endif
        dl_dfe_frm_mrkr = 2'b00;
        cyc(2);

        // Reset mid-DELAY
        cfg_apply_dly = 16'd3;
        arm(8'hC3);
        dl_dfe_frm_mrkr = 2'b01;
        cyc(2);
        reset = 1'b1;
        cyc();
        reset = 1'b0;
        check("mrst_stream", dl_stream_en, 0);
        check("mrst_busy",   update_busy, 0);
        check("mrst_cnt",    update_cnt, 0);
        check("mrst_drop",   req_drop, 0);
        check("mrst_tmo",    mrkr_timeout, 0);
        dl_dfe_frm_mrkr = 2'b00;
        cyc(5);
        check("mrst_no_commit", dl_stream_en, 0);

        // Abort and request together: request discarded, not counted as dropped
        cfg_update_req = 1'b1;
        cfg_abort      = 1'b1;
        cyc();
        cfg_update_req = 1'b0;
        cfg_abort      = 1'b0;
        check("reqabort_busy", update_busy, 0);
        check("reqabort_drop", req_drop, 0);

        // x1en 1-in-4: marker raised on a gated cycle, seen at i=4, delay ticks at i=8,12
        cfg_apply_dly = 16'd2;
        clk_x1en      = 2'b00;
        arm(8'h96);
        dl_dfe_frm_mrkr = 2'b11;
        for (int i = 1; i <= 12; i++) begin
            clk_x1en = (i % 4 == 0) ? 2'b11 : 2'b00;
            cyc();
            if (i == 11) begin
                check("gate_early", dl_stream_en, 8'h00);
                check("gate_busy",  update_busy, 1);
            end
        end
        check("gate_commit", dl_stream_en, 8'h96);
        check("gate_done",   update_done, 1);
        check("gate_cnt",    update_cnt, 1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/jb_dl_dfe_stream_en_ctrl.md
# jb_dl_dfe_stream_en_ctrl

Frame-aligned scheduler for the DL DFE per-carrier/per-antenna stream enables. Software requests a new enable map; the block arms each carrier and waits for that carrier's frame marker plus a programmable delay, then commits the carrier's slice of the map. Committing at a frame boundary means the DFE input stage never mutes or unmutes a stream mid-symbol. Its `dl_stream_en` output drives the stream-enable field of the common control interface consumed by the DL DFE input stage.

## Interface
- N_CARRIERS, 2, number of carriers.
- N_ANTENNAS, 4, antennas per carrier.
- DLY_W, 16, width of apply-delay and timeout counters.
- clk_1x  in  1  sole clock; all logic on its rising edge.
- reset  in  1  synchronous, active-high reset.
- clk_x1en  in  N_CARRIERS  per-carrier sample-rate enable; all per-carrier counting and marker sampling happen only when set.
- dl_dfe_frm_mrkr  in  N_CARRIERS  per-carrier frame marker (level, sampled on clk_x1en).
- cfg_stream_en_req  in  N_CARRIERS*N_ANTENNAS  requested map; bit c*N_ANTENNAS+a = carrier c, antenna a.
- cfg_update_req  in  1  one-cycle pulse: arm all carriers with the current cfg_stream_en_req.
- cfg_abort  in  1  pulse: disarm all carriers without committing.
- cfg_apply_dly  in  DLY_W  x1en ticks between marker edge and commit.
- cfg_mrkr_timeout  in  DLY_W  x1en ticks allowed in ARMED before timeout.
- dl_stream_en  out  N_CARRIERS*N_ANTENNAS  committed map; reset 0 (all muted).
- update_busy  out  1  any carrier not IDLE; reset 0.
- update_done  out  1  one-cycle pulse when the last armed carrier commits; reset 0.
- update_cnt  out  16  count of completed updates, wraps at 0xFFFF→0; reset 0.
- req_drop  out  1  sticky: update_req seen while busy; cleared only by reset.
- mrkr_timeout  out  N_CARRIERS  sticky per-carrier timeout flags; reset 0.

## Operation
- Per-carrier FSM has three states: IDLE, ARMED and DELAY.
- IDLE→ARMED on cfg_update_req while update_busy=0.
  - cfg_stream_en_req is latched into a shadow register on the same cycle.
  - The carrier's timeout counter clears.
- ARMED, on an x1en cycle:
  - Marker rising edge = current marker high and previous x1en-sampled marker low.
  - The previous-sample register runs in every state, so a marker already high at arm does not count as an edge.
  - Edge with cfg_apply_dly=0: commit the shadow slice to dl_stream_en and go IDLE.
  - Edge with cfg_apply_dly>0: go DELAY with counter=1.
  - No edge: increment the timeout counter.
- DELAY, on an x1en cycle:
  - Counter == cfg_apply_dly: commit the slice and go IDLE.
  - Otherwise increment the counter.
  - Marker edges are ignored in DELAY.
- update_done is asserted on the cycle the final carrier's commit becomes visible. update_cnt increments on that same cycle.
- If every carrier times out, update_done is not pulsed and update_cnt does not increment.
- cfg_update_req while busy is ignored and sets req_drop. The shadow register is unchanged.
- cfg_abort wins over every transition in the same cycle:
  - All carriers go IDLE.
  - No commit is made.
  - No done pulse is issued.
- cfg_update_req and cfg_abort in the same cycle: abort wins and the request is discarded (req_drop not set).
- reset mid-update: all state and all outputs return to their reset values. dl_stream_en returns to 0.

## Timing
- Arm: cfg_update_req at cycle T → ARMED and update_busy=1 at T+1.
- Commit: edge detected at x1en cycle M with cfg_apply_dly=0 → dl_stream_en slice updated at M+1.
- Commit with cfg_apply_dly=D>0: the slice updates 1 cycle after the D-th x1en tick following M.
- update_busy falls on the same cycle update_done pulses.
- All outputs are registered. There is no combinational path from input to output.

## Configuration
- JB_DL_DFE_STREAM_CTRL_WDOG_EN defined (marker watchdog compiled in):
  - Timeout triggers when an ARMED carrier's counter reaches cfg_mrkr_timeout.
  - The carrier goes IDLE without commit and sets its mrkr_timeout bit.
  - That carrier is then considered finished for update_done purposes.
- Macro undefined:
  - mrkr_timeout is tied to 0.
  - ARMED waits indefinitely; only cfg_abort or reset exits.

## Test plan
- Commit with delay:
  - Stimulus: reset, map=0x00; x1en always 1; cfg_apply_dly=3; req map=0xA5; marker edge on carrier0 at cycle 10 and on carrier1 at cycle 20.
  - Required: dl_stream_en[3:0]=0x5 at cycle 14; [7:4]=0xA at cycle 24; update_done pulses at 24; update_cnt=1.
- Pre-high marker:
  - Stimulus: marker already high at arm; it falls, then rises 8 ticks later; cfg_apply_dly=0.
  - Required: commit occurs 1 cycle after that rise, not at arm.
- Request while busy:
  - Stimulus: second cfg_update_req with map=0xFF while ARMED.
  - Required: req_drop=1; the first map is committed.
- Abort:
  - Stimulus: cfg_abort while carrier0 is in DELAY.
  - Required: dl_stream_en unchanged; update_busy=0 next cycle; no update_done.
- Watchdog (macro defined):
  - Stimulus: cfg_mrkr_timeout=50; no marker edge on carrier1.
  - Required: mrkr_timeout[1]=1 after 50 ticks; carrier0 commits; update_done pulses once.
  - Repeat with the macro undefined: busy stays 1 until cfg_abort.
- Reset and x1en gating:
  - Stimulus: reset mid-DELAY; then x1en asserted 1-in-4.
  - Required: all outputs 0 after reset; delay and timeout counts advance only on enabled cycles.
